// File: rtl/axil_app_master.sv
// AXI4-Lite master bridge: turns single-beat application write/read requests into
// AXI4-Lite transactions. Write and read engines are independent.
// Optional build macro AXIL_APP_RESP_STATUS_EN adds app_wresp/app_rresp status outputs.
module axil_app_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // Application side
  input  logic [ADDR_WIDTH-1:0] app_waddr,
  input  logic [DATA_WIDTH-1:0] app_wdata,
  input  logic                  app_wen,
  output logic                  app_wdone,
  input  logic [ADDR_WIDTH-1:0] app_raddr,
  input  logic                  app_ren,
  output logic [DATA_WIDTH-1:0] app_rdata,
`ifdef AXIL_APP_RESP_STATUS_EN
  output logic [1:0]            app_wresp,
  output logic [1:0]            app_rresp,
`endif
  output logic                  app_rdone
);

  typedef enum logic [1:0] {WrIdle, WrXfer, WrResp, WrDone} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdAddr, RdData, RdDone} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic wdone_q, wdone_d, rdone_q, rdone_d;

`ifdef AXIL_APP_RESP_STATUS_EN
  logic [1:0] wresp_q, wresp_d, rresp_q, rresp_d;
`else
  // Response codes are not reported in this build.
  logic unused_resp;
  assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
`endif

  // Write engine: next state and registered outputs.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    wdone_d    = 1'b0;
`ifdef AXIL_APP_RESP_STATUS_EN
    wresp_d    = wresp_q;
`endif
    unique case (wr_state_q)
      WrIdle: begin
        if (app_wen) begin
          awaddr_d   = app_waddr;
          wdata_d    = app_wdata;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_state_d = WrXfer;
        end
      end
      WrXfer: begin
        // AW and W handshakes complete independently, in any order.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d   = 1'b1;
          wr_state_d = WrResp;
        end
      end
      WrResp: begin
        if (m_axi_bvalid) begin
          bready_d   = 1'b0;
          wr_state_d = WrDone;
`ifdef AXIL_APP_RESP_STATUS_EN
          wresp_d    = m_axi_bresp;
`endif
        end
      end
      WrDone: begin
        wdone_d    = 1'b1;
        wr_state_d = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Read engine: next state and registered outputs.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rdone_d    = 1'b0;
`ifdef AXIL_APP_RESP_STATUS_EN
    rresp_d    = rresp_q;
`endif
    unique case (rd_state_q)
      RdIdle: begin
        // Level-sensitive: a held app_ren issues back-to-back reads.
        if (app_ren) begin
          araddr_d   = app_raddr;
          arvalid_d  = 1'b1;
          rd_state_d = RdAddr;
        end
      end
      RdAddr: begin
        if (m_axi_arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = RdData;
        end
      end
      RdData: begin
        if (m_axi_rvalid) begin
          rdata_d    = m_axi_rdata;
          rready_d   = 1'b0;
          rd_state_d = RdDone;
`ifdef AXIL_APP_RESP_STATUS_EN
          rresp_d    = m_axi_rresp;
`endif
        end
      end
      RdDone: begin
        rdone_d    = 1'b1;
        rd_state_d = RdIdle;
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // State and output registers; reset discards any transfer in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      rdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      wdone_q    <= 1'b0;
      rdone_q    <= 1'b0;
`ifdef AXIL_APP_RESP_STATUS_EN
      wresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
      rdata_q    <= rdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      wdone_q    <= wdone_d;
      rdone_q    <= rdone_d;
`ifdef AXIL_APP_RESP_STATUS_EN
      wresp_q    <= wresp_d;
      rresp_q    <= rresp_d;
`endif
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign app_wdone     = wdone_q;
  assign app_rdone     = rdone_q;
  assign app_rdata     = rdata_q;
`ifdef AXIL_APP_RESP_STATUS_EN
  assign app_wresp     = wresp_q;
  assign app_rresp     = rresp_q;
`endif

endmodule

// File: tb/tb_axil_app_master.sv
// Directed bench for axil_app_master with a small AXI-Lite memory slave whose
// AW/W ready and B response delays are programmable.
module tb_axil_app_master;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] app_waddr, app_wdata, app_raddr, app_rdata;
  logic        app_wen, app_wdone, app_ren, app_rdone;
`ifdef AXIL_APP_RESP_STATUS_EN
  logic [1:0]  app_wresp, app_rresp;
`endif

  always #5 aclk = ~aclk;

  axil_app_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .app_waddr     (app_waddr),
    .app_wdata     (app_wdata),
    .app_wen       (app_wen),
    .app_wdone     (app_wdone),
    .app_raddr     (app_raddr),
    .app_ren       (app_ren),
    .app_rdata     (app_rdata),
`ifdef AXIL_APP_RESP_STATUS_EN
    .app_wresp     (app_wresp),
    .app_rresp     (app_rresp),
`endif
    .app_rdone     (app_rdone)
  );

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_cnt, w_cnt, b_cnt;
  logic        aw_got, w_got, b_pend;
  logic [31:0] aw_addr_s, w_data_s;
  logic [31:0] mem [16];
  logic        aw_hs, w_hs, ar_hs, wr_complete;
  logic [31:0] wr_addr_now, wr_data_now;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt == aw_delay);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt == w_delay);
  assign m_axi_arready = m_axi_arvalid;
  assign m_axi_bresp   = bresp_cfg;
  assign m_axi_rresp   = rresp_cfg;
  assign aw_hs         = m_axi_awvalid && m_axi_awready;
  assign w_hs          = m_axi_wvalid && m_axi_wready;
  assign ar_hs         = m_axi_arvalid && m_axi_arready;
  assign wr_complete   = (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_addr_now   = aw_hs ? m_axi_awaddr : aw_addr_s;
  assign wr_data_now   = w_hs ? m_axi_wdata : w_data_s;

  // Memory slave; a read hitting a write completing on the same edge sees the new data.
  always @(posedge aclk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0; m_axi_rdata <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= m_axi_awaddr; end
      if (w_hs)  begin w_got <= 1'b1; w_data_s <= m_axi_wdata; end
      if (wr_complete) begin
        mem[wr_addr_now[5:2]] <= wr_data_now;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (b_delay == 0) m_axi_bvalid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= b_delay; end
      end
      if (b_pend) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) begin m_axi_bvalid <= 1'b1; b_pend <= 1'b0; end
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (ar_hs) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= (wr_complete && wr_addr_now[5:2] == m_axi_araddr[5:2]) ?
                        wr_data_now : mem[m_axi_araddr[5:2]];
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int          wdone_cnt = 0, rdone_cnt = 0, aw_hs_cnt = 0, viol_cnt = 0;
  logic        rst_p = 1'b1, awv_p = 1'b0, wv_p = 1'b0, arv_p = 1'b0;
  logic        awhs_p = 1'b0, whs_p = 1'b0, arhs_p = 1'b0;
  logic [31:0] awaddr_p, wdata_p, araddr_p;

  // Count done cycles / AW handshakes and flag any valid dropped or changed before handshake.
  always @(posedge aclk) begin
    if (app_wdone) wdone_cnt <= wdone_cnt + 1;
    if (app_rdone) rdone_cnt <= rdone_cnt + 1;
    if (aw_hs)     aw_hs_cnt <= aw_hs_cnt + 1;
    if (!rst_p && ((awv_p && !awhs_p && (!m_axi_awvalid || m_axi_awaddr != awaddr_p)) ||
                   (wv_p && !whs_p && (!m_axi_wvalid || m_axi_wdata != wdata_p)) ||
                   (arv_p && !arhs_p && (!m_axi_arvalid || m_axi_araddr != araddr_p))))
      viol_cnt <= viol_cnt + 1;
    rst_p <= areset;
    awv_p <= m_axi_awvalid; awhs_p <= aw_hs; awaddr_p <= m_axi_awaddr;
    wv_p  <= m_axi_wvalid;  whs_p  <= w_hs;  wdata_p  <= m_axi_wdata;
    arv_p <= m_axi_arvalid; arhs_p <= ar_hs; araddr_p <= m_axi_araddr;
  end

  // ---------------- checking ----------------
  int check_cnt = 0, err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          wlat, rlat;
  logic [31:0] rdat, s_awaddr, s_wdata, s_araddr;
  logic        s_awv, s_wv, s_arv;

  // Issue a one-cycle wen and/or ren; latencies count negedges after the sampling edge.
  task automatic run_req(input bit do_w, input bit do_r, input logic [31:0] waddr,
                         input logic [31:0] wdat, input logic [31:0] raddr);
    wlat = 0; rlat = 0; rdat = '0;
    @(negedge aclk);
    app_wen = do_w; app_waddr = waddr; app_wdata = wdat;
    app_ren = do_r; app_raddr = raddr;
    for (int i = 1; i <= 40; i++) begin
      @(negedge aclk);
      if (i == 1) begin
        app_wen = 1'b0; app_ren = 1'b0;
        s_awv = m_axi_awvalid; s_wv = m_axi_wvalid; s_arv = m_axi_arvalid;
        s_awaddr = m_axi_awaddr; s_wdata = m_axi_wdata; s_araddr = m_axi_araddr;
      end
      if (app_wdone && wlat == 0) wlat = i;
      if (app_rdone && rlat == 0) begin rlat = i; rdat = app_rdata; end
      if ((!do_w || wlat != 0) && (!do_r || rlat != 0)) break;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  int w0, a0, pulses, bad;

  initial begin
    areset = 1'b1; app_wen = 1'b0; app_ren = 1'b0;
    app_waddr = '0; app_wdata = '0; app_raddr = '0;
    idle_cycles(3);
    areset = 1'b0;
    @(negedge aclk);
    check_eq("rst_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
    check_eq("rst_wvalid",  {31'd0, m_axi_wvalid},  32'd0);
    check_eq("rst_bready",  {31'd0, m_axi_bready},  32'd0);
    check_eq("rst_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
    check_eq("rst_rready",  {31'd0, m_axi_rready},  32'd0);
    check_eq("rst_dones",   {30'd0, app_wdone, app_rdone}, 32'd0);
    check_eq("rst_rdata",   app_rdata, 32'd0);
    check_eq("rst_awaddr",  m_axi_awaddr, 32'd0);

    // Zero-wait write.
    w0 = wdone_cnt;
    run_req(1'b1, 1'b0, 32'hAAAABBBB, 32'h5AA5A55A, 32'h0);
    check_eq("wr_awaddr", s_awaddr, 32'hAAAABBBB);
    check_eq("wr_wdata",  s_wdata,  32'h5AA5A55A);
    check_eq("wr_valids", {30'd0, s_awv, s_wv}, 32'd3);
    check_eq("wr_wstrb_prot", {25'd0, m_axi_wstrb, m_axi_awprot}, {25'd0, 4'hF, 3'b000});
    check_eq("wr_latency", wlat, 32'd4);
    idle_cycles(3);
    check_eq("wr_done_cycles", wdone_cnt - w0, 32'd1);

    // Held ren: back-to-back reads every 4 cycles.
    pulses = 0; bad = 0;
    @(negedge aclk);
    app_ren = 1'b1; app_raddr = 32'hAAAABBBB;
    for (int i = 1; i <= 20; i++) begin
      @(negedge aclk);
      if (i == 1) s_araddr = m_axi_araddr;
      if (app_rdone) begin
        pulses++;
        if (app_rdata !== 32'h5AA5A55A) bad++;
      end
    end
    app_ren = 1'b0;
    check_eq("rd_araddr", s_araddr, 32'hAAAABBBB);
    check_eq("rd_b2b_pulses", pulses, 32'd5);
    check_eq("rd_b2b_bad_data", bad, 32'd0);
    check_eq("rd_arprot", {29'd0, m_axi_arprot}, 32'd0);
    idle_cycles(4);

    // Simultaneous write and read of the same address.
    run_req(1'b1, 1'b1, 32'h00000040, 32'hCAFEF00D, 32'h00000040);
    check_eq("fork_valids", {29'd0, s_awv, s_wv, s_arv}, 32'd7);
    check_eq("fork_wlat", wlat, 32'd4);
    check_eq("fork_rlat", rlat, 32'd4);
    check_eq("fork_rdata", rdat, 32'hCAFEF00D);
    idle_cycles(5);
    check_eq("rdata_held", app_rdata, 32'hCAFEF00D);

    // Slow slave: awready +3, wready +1, bvalid +5.
    aw_delay = 3; w_delay = 1; b_delay = 5;
    w0 = wdone_cnt; a0 = aw_hs_cnt;
    run_req(1'b1, 1'b0, 32'h00000010, 32'h13572468, 32'h0);
    idle_cycles(3);
    check_eq("slow_wlat", wlat, 32'd12);
    check_eq("slow_done_cycles", wdone_cnt - w0, 32'd1);
    check_eq("slow_aw_count", aw_hs_cnt - a0, 32'd1);
    check_eq("valid_stability_violations", viol_cnt, 32'd0);

    // Second wen while in XFER is ignored.
    aw_delay = 3; w_delay = 0; b_delay = 0;
    w0 = wdone_cnt; a0 = aw_hs_cnt; wlat = 0;
    @(negedge aclk);
    app_wen = 1'b1; app_waddr = 32'h00000030; app_wdata = 32'h24681357;
    for (int i = 1; i <= 40; i++) begin
      @(negedge aclk);
      app_wen = (i == 2);
      if (i == 2) begin app_waddr = 32'h00000034; app_wdata = 32'h11111111; end
      if (app_wdone && wlat == 0) wlat = i;
    end
    check_eq("ign_wlat", wlat, 32'd7);
    check_eq("ign_aw_count", aw_hs_cnt - a0, 32'd1);
    check_eq("ign_done_cycles", wdone_cnt - w0, 32'd1);

    // Reset while awvalid is high.
    w0 = wdone_cnt;
    @(negedge aclk);
    app_wen = 1'b1; app_waddr = 32'h00000020; app_wdata = 32'h99999999;
    @(negedge aclk);
    app_wen = 1'b0;
    @(negedge aclk);
    check_eq("pre_rst_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check_eq("mid_rst_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
    check_eq("mid_rst_bready", {31'd0, m_axi_bready}, 32'd0);
    idle_cycles(10);
    check_eq("mid_rst_no_wdone", wdone_cnt - w0, 32'd0);
    aw_delay = 0;
    run_req(1'b1, 1'b0, 32'h00000024, 32'h0F0F0F0F, 32'h0);
    check_eq("post_rst_wlat", wlat, 32'd4);

    // Error responses still complete.
    bresp_cfg = 2'b10; rresp_cfg = 2'b10;
    run_req(1'b1, 1'b0, 32'h00000008, 32'h0BADF00D, 32'h0);
    check_eq("slverr_wlat", wlat, 32'd4);
`ifdef AXIL_APP_RESP_STATUS_EN
    check_eq("slverr_wresp", {30'd0, app_wresp}, 32'd2);
`endif
    run_req(1'b0, 1'b1, 32'h0, 32'h0, 32'h00000008);
    check_eq("slverr_rlat", rlat, 32'd4);
    check_eq("slverr_rdata", rdat, 32'h0BADF00D);
`ifdef AXIL_APP_RESP_STATUS_EN
    check_eq("slverr_rresp", {30'd0, app_rresp}, 32'd2);
    bresp_cfg = 2'b00;
    run_req(1'b1, 1'b0, 32'h0000000C, 32'h00000001, 32'h0);
    check_eq("okay_wresp", {30'd0, app_wresp}, 32'd0);
    check_eq("rresp_held", {30'd0, app_rresp}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axil_app_master.md
Name: axil_app_master

Overview:
- AXI4-Lite master bridge. It converts a simple single-beat application write/read request interface into AXI4-Lite transactions on a 32-bit bus.
- Write and read engines are independent and may run concurrently.
- Sits between user logic and an AXI-Lite slave (register block or memory).

Parameters:
- ADDR_WIDTH, 32, AXI/app address width.
- DATA_WIDTH, 32, AXI/app data width; must be 32 (wstrb is 4 bits).

Ports:
- aclk  in  1  single clock; all logic rising-edge.
- areset  in  1  reset; one clock; reset is synchronous and active-high.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awprot  out  3  constant 3'b000.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_wstrb  out  4  constant 4'hF.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- app_waddr  in  ADDR_WIDTH  write address, sampled with app_wen.
- app_wdata  in  DATA_WIDTH  write data, sampled with app_wen.
- app_wen  in  1  write request.
- app_wdone  out  1  one-cycle pulse when write completes.
- app_raddr  in  ADDR_WIDTH  read address, sampled with app_ren.
- app_ren  in  1  read request.
- app_rdata  out  DATA_WIDTH  last read data, held until the next read completes.
- app_rdone  out  1  one-cycle pulse when read completes; app_rdata is valid in the same cycle.

Behaviour:
- Reset values: all valid/ready outputs, app_wdone and app_rdone are 0. Address, data and app_rdata registers are 0. Both FSMs go to IDLE.
- All outputs are registered.

Write FSM (IDLE, XFER, RESP, DONE):
- IDLE: if app_wen=1 at edge N, capture app_waddr/app_wdata and go to XFER. awvalid and wvalid are both 1 from cycle N+1.
- XFER: awvalid drops the cycle after awvalid&awready. wvalid drops the cycle after wvalid&wready. The two handshakes may occur in either order or in the same cycle. Once both have occurred, go to RESP with bready=1.
- RESP: on bvalid&bready, bready drops and the FSM goes to DONE. app_wdone=1 for exactly one cycle, then IDLE.
- awaddr/wdata are stable while their valid is high. A valid is never withdrawn before its handshake.
- app_wen outside IDLE is ignored (no queueing).

Read FSM (IDLE, ADDR, DATA, DONE):
- IDLE: app_ren=1 at edge N captures app_raddr; arvalid=1 from N+1.
- ADDR: on arvalid&arready, arvalid drops and rready=1.
- DATA: on rvalid&rready, capture rdata into app_rdata and drop rready. Go to DONE; app_rdone pulses one cycle, then IDLE.
- app_ren is level-sensitive. If it is still high when the FSM returns to IDLE, a new read starts (back-to-back reads, address re-sampled).

Other rules:
- Write and read FSMs run fully independently; simultaneous wen and ren both issue at N+1.
- Responses other than OKAY still complete normally; data is captured regardless.
- Minimum latency with a zero-wait slave: wen at N, wdone at N+4. ren at N, rdone at N+4.
- Reset mid-operation: at the next edge all valids/readies drop, FSMs go to IDLE, the pending request is discarded, and no done pulse is issued.

Optional Feature:
- Macro AXIL_APP_RESP_STATUS_EN.
- Defined: adds outputs app_wresp[1:0] and app_rresp[1:0]. They capture bresp on the B handshake and rresp on the R handshake, are valid with the done pulses, are held until the next completion, and reset to 0.
- Undefined: these ports do not exist, and bresp/rresp are ignored.

Test Plan:
- Write 0x5AA5A55A to 0xAAAABBBB, zero-wait memory slave -> awaddr=0xAAAABBBB, wdata=0x5AA5A55A, wstrb=F, prot=0; single app_wdone pulse at N+4.
- Write then read 0xAAAABBBB (ren held high) -> every app_rdone pulse shows app_rdata=0x5AA5A55A; reads repeat back-to-back.
- wen and ren in the same cycle (fork) -> awvalid, wvalid and arvalid all rise together; both dones occur and the read returns the written data.
- Slave delays awready 3 cycles and wready 1 cycle, and asserts bvalid 5 cycles late -> valids hold stable until their handshakes; exactly one wdone.
- Second wen pulse while a write is in XFER -> ignored; only one AW transaction.
- Reset asserted while awvalid=1 -> awvalid=0 and FSM IDLE next cycle; no wdone. With AXIL_APP_RESP_STATUS_EN, a slave returning SLVERR gives app_wresp=2'b10.
